temp_conv_sched: RTL and testbench
==================================

TEMP_CONV_SCHED -- requirements
Module: temp_conv_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 3, giving the number of requesting heater channels (0 = hotend0, 1 = hotend1, 2 = bed).
REQ-002 The block SHALL have parameter CONV_LAT, default 1, giving the shared converter latency in clock edges (legal range 1..15).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NCH  per-channel conversion request, sampled each edge.
REQ-006 req_temp  input  NCH*12  per-channel signed setpoint in degrees C; channel i occupies bits [12*i+11:12*i].
REQ-007 conv_temp  output  12  signed temperature driven to the shared temperature-to-ADC converter.
REQ-008 conv_adc  input  12  converter result (expected ADC code).
REQ-009 adc_target  output  NCH*12  per-channel stored ADC code, same packing as req_temp.
REQ-010 target_valid  output  NCH  channel has held a stored result since reset.
REQ-011 done  output  NCH  one-cycle pulse when the channel's result is stored.
REQ-012 clamp_err  output  NCH  sticky flag: the last conversion of the channel was clamped.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 A pending bit per channel SHALL be set on any edge where req[i]=1 and cleared when channel i is granted; if set and clear coincide, set SHALL win.
REQ-015 Repeated requests while pending SHALL merge into one conversion.
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and STORE.
REQ-017 IDLE SHALL go to ISSUE on the edge after any pending bit is set; otherwise it SHALL stay in IDLE.
REQ-018 In ISSUE, the grant SHALL be round-robin: search starts at channel (last_grant+1) mod NCH; after reset, last_grant = NCH-1, so channel 0 has first priority.
REQ-019 On the edge leaving ISSUE, conv_temp SHALL load the clamped req_temp of the granted channel (sampled in that cycle), the channel's pending bit SHALL clear, and the wait counter SHALL load CONV_LAT-1.
REQ-020 Clamping SHALL be signed: values below -55 become -55, values above 300 become 300; clamp_err[g] SHALL be set if clamped and cleared otherwise.
REQ-021 WAIT SHALL decrement the counter each edge and go to STORE when the counter is 0; total WAIT duration SHALL be CONV_LAT cycles.
REQ-022 conv_temp SHALL hold its value from ISSUE through STORE.
REQ-023 In STORE, conv_adc SHALL be captured into adc_target[g] exactly CONV_LAT+1 edges after conv_temp loaded.
REQ-024 On that same STORE edge, target_valid[g] SHALL be set and done[g] SHALL pulse high for one cycle.
REQ-025 STORE SHALL go to ISSUE if any pending bit is set (including a new request for g), otherwise to IDLE.
REQ-026 Per-request latency SHALL be CONV_LAT+3 edges from req to done (req, ISSUE, WAIT x CONV_LAT, STORE), assuming no contention.
REQ-027 Only one conversion SHALL be in flight at any time; adc_target of non-granted channels SHALL never change.

Reset
REQ-028 When rst_n=0, the FSM SHALL be in IDLE, all pending bits SHALL be 0, and last_grant SHALL be NCH-1.
REQ-029 When rst_n=0, conv_temp, adc_target, target_valid, done, clamp_err and busy SHALL all be 0, and the wait counter SHALL be 0.
REQ-030 Reset asserted mid-conversion SHALL abort it with no done pulse and no adc_target update; requests pending at reset SHALL be lost.

Verification
REQ-031 Single request: req[0] pulse, req_temp0=200, converter model returns 12'h5A3 with CONV_LAT=1 -> conv_temp=200; adc_target0=12'h5A3 and done[0] pulse 4 edges after req; busy low afterwards.
REQ-032 Contention: req=3'b111 in one cycle -> service order 0,1,2; three done pulses spaced CONV_LAT+2 cycles apart; next simultaneous burst starts again at channel 0.
REQ-033 Clamp: req_temp1=-100 -> conv_temp=-55 and clamp_err[1]=1; req_temp1=350 -> conv_temp=300; req_temp1=25 -> clamp_err[1]=0.
REQ-034 Re-request during service: req[2] asserted in WAIT for channel 2 with a new temp -> second conversion of channel 2 uses the new value; no request is lost.
REQ-035 Reset mid-WAIT with CONV_LAT=4 -> no done pulse, all outputs 0; a request after reset release completes normally.

Source files
------------

// File: rtl/temp_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : temp_conv_sched
//  Description : Round-robin scheduler that shares one temperature-to-ADC
//                converter between NCH heater channels. Each channel posts a
//                setpoint request; the block clamps it, drives the converter,
//                waits CONV_LAT cycles and stores the resulting ADC code.
//  Revision    : 1.0 - initial release
// ============================================================================
module temp_conv_sched #(
    parameter int NCH      = 3,
    parameter int CONV_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*12-1:0]    req_temp,
    output logic [11:0]          conv_temp,
    input  logic [11:0]          conv_adc,
    output logic [NCH*12-1:0]    adc_target,
    output logic [NCH-1:0]       target_valid,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       clamp_err,
    output logic                 busy
);

    localparam int                GW          = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [GW:0]       C_NCH       = (GW+1)'(NCH);
    localparam logic [GW-1:0]     C_LAST_RST  = GW'(NCH - 1);
    localparam logic [NCH-1:0]    C_ONE       = NCH'(1);
    localparam logic [3:0]        C_WAIT_INIT = 4'(CONV_LAT - 1);
    localparam logic signed [11:0] C_TMIN     = -12'sd55;
    localparam logic signed [11:0] C_TMAX     = 12'sd300;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [NCH-1:0]         r_pending;
    logic [GW-1:0]          r_last_grant;
    logic [3:0]             r_cnt;
    logic [11:0]            r_conv_temp;
    logic [11:0]            r_adc [NCH];
    logic [NCH-1:0]         r_valid;
    logic [NCH-1:0]         r_done;
    logic [NCH-1:0]         r_clamp;

    logic signed [11:0]     w_temp [NCH];
    logic [GW-1:0]          w_pick;
    logic                   w_found;
    logic [GW:0]            w_sum;
    logic signed [11:0]     w_sel_temp;
    logic signed [11:0]     w_clamped;
    logic                   w_clip;
    logic [NCH-1:0]         w_clr;

    // Unpack the per-channel setpoints and pack the stored codes.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign w_temp[i]              = req_temp[12*i +: 12];
        assign adc_target[12*i +: 12] = r_adc[i];
    end

    assign conv_temp    = r_conv_temp;
    assign target_valid = r_valid;
    assign done         = r_done;
    assign clamp_err    = r_clamp;
    assign busy         = (r_state != S_IDLE);

    // Round-robin pick: first pending channel after the last grant, wrapping.
    always_comb begin
        w_pick  = r_last_grant;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_sum = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_sum >= C_NCH) begin
                w_sum = w_sum - C_NCH;
            end
            if (!w_found && r_pending[w_sum[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[GW-1:0];
            end
        end
    end

    // Signed clamp of the picked setpoint into the converter's legal range.
    always_comb begin
        w_sel_temp = w_temp[w_pick];
        w_clamped  = w_sel_temp;
        w_clip     = 1'b0;
        if (w_sel_temp < C_TMIN) begin
            w_clamped = C_TMIN;
            w_clip    = 1'b1;
        end else if (w_sel_temp > C_TMAX) begin
            w_clamped = C_TMAX;
            w_clip    = 1'b1;
        end
    end

    // Next-state logic and the pending-clear mask for the granted channel.
    always_comb begin
        w_next = r_state;
        w_clr  = '0;
        unique case (r_state)
            S_IDLE:  if (|r_pending) w_next = S_ISSUE;
            S_ISSUE: begin
                w_next = S_WAIT;
                w_clr  = C_ONE << w_pick;
            end
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_STORE;
            S_STORE: w_next = (|r_pending) ? S_ISSUE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: pending bits (set beats clear), grant, wait counter, results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_last_grant <= C_LAST_RST;
            r_cnt        <= 4'd0;
            r_conv_temp  <= 12'd0;
            r_valid      <= '0;
            r_done       <= '0;
            r_clamp      <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_adc[i] <= 12'd0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | req;
            r_done    <= '0;
            if (r_state == S_ISSUE) begin
                r_last_grant    <= w_pick;
                r_conv_temp     <= w_clamped;
                r_clamp[w_pick] <= w_clip;
                r_cnt           <= C_WAIT_INIT;
            end
            if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_STORE) begin
                r_adc[r_last_grant]   <= conv_adc;
                r_valid[r_last_grant] <= 1'b1;
                r_done[r_last_grant]  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temp_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temp_conv_sched
//  Description : Scoreboard bench for temp_conv_sched; two instances with
//                converter latencies 1 and 4 share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_conv_sched;

    localparam int NCH = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [NCH*12-1:0] req_temp;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          ch;
        logic [11:0] temp;
        logic [11:0] adc;
    } exp_t;

    always #5 clk = ~clk;

    // Converter range rules as plain arithmetic.
    function automatic logic [11:0] clampf(input logic signed [11:0] t);
        if (t < -12'sd55) return 12'hFC9;     // -55
        if (t > 12'sd300) return 12'd300;
        return t;
    endfunction

    function automatic bit clippedf(input logic signed [11:0] t);
        return (t < -12'sd55) || (t > 12'sd300);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        nvec++;
        if (act !== req_v) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_v);
        end
    endtask

    for (genvar j = 0; j < 2; j++) begin : g_inst
        localparam int LAT = (j == 0) ? 1 : 4;

        logic [11:0]       conv_temp;
        logic [11:0]       conv_adc;
        logic [NCH*12-1:0] adc_target;
        logic [NCH-1:0]    target_valid;
        logic [NCH-1:0]    done;
        logic [NCH-1:0]    clamp_err;
        logic              busy;

        // Converter stand-in: a fixed offset makes every code traceable.
        assign conv_adc = conv_temp + 12'h4DB;

        temp_conv_sched #(.NCH(NCH), .CONV_LAT(LAT)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req          (req),
            .req_temp     (req_temp),
            .conv_temp    (conv_temp),
            .conv_adc     (conv_adc),
            .adc_target   (adc_target),
            .target_valid (target_valid),
            .done         (done),
            .clamp_err    (clamp_err),
            .busy         (busy)
        );

        // Timeline reference: edges at which the next grant / store occur.
        logic [NCH-1:0]    m_pend, m_pre, m_valid, m_clamp;
        logic [11:0]       m_adc [NCH];
        logic [NCH*12-1:0] m_adc_p;
        int                m_last, m_grant_edge, m_store_edge, m_cyc, m_g;
        bit                m_idle, m_found;
        exp_t              m_job, m_e;
        exp_t              q[$];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_pend = '0; m_valid = '0; m_clamp = '0;
                for (int i = 0; i < NCH; i++) m_adc[i] = '0;
                m_last = NCH - 1; m_grant_edge = -1; m_store_edge = -1;
                m_cyc = 0; m_idle = 1'b1;
                q.delete();
            end else begin
                m_cyc++;
                m_pre = m_pend;
                if (m_idle && (|m_pre)) begin
                    m_idle       = 1'b0;
                    m_grant_edge = m_cyc + 1;
                end
                if (m_grant_edge == m_cyc) begin
                    m_found = 1'b0;
                    m_g     = 0;
                    for (int k = 1; k <= NCH; k++) begin
                        if (!m_found && m_pre[(m_last + k) % NCH]) begin
                            m_found = 1'b1;
                            m_g     = (m_last + k) % NCH;
                        end
                    end
                    m_job.ch       = m_g;
                    m_job.temp     = clampf(req_temp[12*m_g +: 12]);
                    m_job.adc      = m_job.temp + 12'h4DB;
                    m_clamp[m_g]   = clippedf(req_temp[12*m_g +: 12]);
                    m_pend[m_g]    = 1'b0;
                    m_last         = m_g;
                    m_store_edge   = m_cyc + LAT + 1;
                    m_grant_edge   = -1;
                end
                if (m_store_edge == m_cyc) begin
                    m_adc[m_job.ch]   = m_job.adc;
                    m_valid[m_job.ch] = 1'b1;
                    q.push_back(m_job);
                    m_store_edge = -1;
                    if (|m_pre) m_grant_edge = m_cyc + 1;
                    else        m_idle = 1'b1;
                end
                m_pend = m_pend | req;
            end
        end

        // Monitor: compare on the falling edge, away from state changes.
        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("L%0d rst conv_temp", LAT), conv_temp, 0);
                chk($sformatf("L%0d rst adc_target", LAT), adc_target, 0);
                chk($sformatf("L%0d rst target_valid", LAT), target_valid, 0);
                chk($sformatf("L%0d rst done", LAT), done, 0);
                chk($sformatf("L%0d rst clamp_err", LAT), clamp_err, 0);
                chk($sformatf("L%0d rst busy", LAT), busy, 0);
            end else begin
                for (int i = 0; i < NCH; i++) m_adc_p[12*i +: 12] = m_adc[i];
                chk($sformatf("L%0d busy", LAT), busy, !m_idle);
                chk($sformatf("L%0d target_valid", LAT), target_valid, m_valid);
                chk($sformatf("L%0d clamp_err", LAT), clamp_err, m_clamp);
                chk($sformatf("L%0d adc_target", LAT), adc_target, m_adc_p);
                if (done != '0) begin
                    if (q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL L%0d done_unexpected: got done=%b, required none", LAT, done);
                    end else begin
                        m_e = q.pop_front();
                        chk($sformatf("L%0d done_channel", LAT), done, 64'd1 << m_e.ch);
                        chk($sformatf("L%0d conv_temp", LAT), conv_temp, m_e.temp);
                    end
                end else if (q.size() != 0) begin
                    m_e = q.pop_front();
                    nvec++; nerr++;
                    $display("FAIL L%0d done_missing: got done=0, required channel %0d", LAT, m_e.ch);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_temp(input int ch, input int t);
        req_temp[12*ch +: 12] = 12'(t);
    endtask

    task automatic pulse(input logic [NCH-1:0] r);
        req = r;
        tick(1);
        req = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(g_inst[0].m_idle && g_inst[1].m_idle &&
                 g_inst[0].m_pend == '0 && g_inst[1].m_pend == '0 &&
                 !g_inst[0].busy && !g_inst[1].busy) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) begin
            nvec++; nerr++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
        end
        tick(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_temp = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single request on channel 0.
        set_temp(0, 200);
        pulse(3'b001);
        wait_idle();
        chk("single adc0 L1", g_inst[0].adc_target[11:0], 12'h5A3);
        chk("single busy L1", g_inst[0].busy, 0);

        // Contention bursts: order 0,1,2 each time.
        set_temp(0, 10); set_temp(1, 20); set_temp(2, 30);
        pulse(3'b111);
        wait_idle();
        set_temp(0, 11); set_temp(1, 21); set_temp(2, 31);
        pulse(3'b111);
        wait_idle();

        // Clamp boundaries on channel 1.
        set_temp(1, -100);
        pulse(3'b010);
        wait_idle();
        chk("clamp lo conv_temp", g_inst[1].conv_temp, 12'hFC9);
        chk("clamp lo flag", g_inst[1].clamp_err[1], 1);
        set_temp(1, 350);
        pulse(3'b010);
        wait_idle();
        chk("clamp hi conv_temp", g_inst[1].conv_temp, 12'd300);
        set_temp(1, 25);
        pulse(3'b010);
        wait_idle();
        chk("clamp clear flag", g_inst[1].clamp_err[1], 0);

        // Re-request of channel 2 while its first conversion is in WAIT.
        set_temp(2, 100);
        pulse(3'b100);
        tick(3);
        set_temp(2, 150);
        pulse(3'b100);
        wait_idle();
        chk("rereq adc2 L4", g_inst[1].adc_target[35:24], 12'(150 + 12'h4DB));

        // Reset mid-WAIT, then a normal request.
        set_temp(0, 40);
        pulse(3'b001);
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        set_temp(0, 77);
        pulse(3'b001);
        wait_idle();
        chk("post-reset adc0 L4", g_inst[1].adc_target[11:0], 12'(77 + 12'h4DB));

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                req[i] = ($urandom_range(0, 99) < 15);
                if ($urandom_range(0, 3) == 0)
                    set_temp(i, int'($urandom_range(0, 800)) - 300);
            end
            tick(1);
        end
        req = '0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
